text_top: RTL and testbench



---
 rtl/text_top.sv | 95 +++++++++
 tb/tb_text_top.sv | 115 +++++++++++
 2 files changed

// File: rtl/text_top.sv
// Text source ROM serialised MSB-first over an internal loopback and rebuilt on data_out.
// Optional build macro TEXT_UPPERCASE_EN folds received 'a'..'z' to uppercase.

module text_rom #(
  parameter int    DEPTH     = 256,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = "contents.txt"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        rom_q
);

  logic [7:0] mem [0:DEPTH-1];

  // Synchronous read with one cycle of latency; contents are filled hierarchically.
  always_ff @(posedge clk) begin
    rom_q <= mem[addr];
  end

endmodule

module text_top #(
  parameter int    DEPTH     = 256,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = "contents.txt"
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] data_out
);

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        bit_cnt;
  logic              primed;
  logic [7:0]        tx_sr;
  logic [7:0]        rx_sr;
  logic [7:0]        rom_q;
  logic              s;
  logic [7:0]        rx_byte;

  // Reading address 0 while in reset guarantees the prime cycle sees mem[0],
  // even after a single-cycle reset that lands mid-frame.
  assign rd_addr = reset ? '0 : addr;

  text_rom #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) source (
    .clk  (clk),
    .addr (rd_addr),
    .rom_q(rom_q)
  );

  assign s       = tx_sr[7];
  assign rx_byte = {rx_sr[6:0], s};

  function automatic logic [7:0] to_output(input logic [7:0] b);
`ifdef TEXT_UPPERCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    else return b;
`else
    return b;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= '0;
      bit_cnt  <= '0;
      primed   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      data_out <= '0;
    end else if (!primed) begin
      tx_sr   <= rom_q;
      addr    <= ADDR_W'(1);
      primed  <= 1'b1;
      bit_cnt <= '0;
    end else begin
      rx_sr   <= rx_byte;
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        data_out <= to_output(rx_byte);
        tx_sr    <= rom_q;
        addr     <= addr + ADDR_W'(1);
      end else begin
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_text_top.sv
// Directed bench for text_top: a 4-byte ROM image is loaded hierarchically and data_out is checked every edge.

module tb_text_top;

  logic       clk;
  logic       reset;
  logic [7:0] data_out;

  int assertions;
  int failures;
  logic [7:0] img [4];

  text_top #(
    .DEPTH    (4),
    .ADDR_W   (2),
    .INIT_FILE("")
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte the receiver should present for a given ROM byte.
  function automatic logic [7:0] expectByte(input logic [7:0] b);
`ifdef TEXT_UPPERCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    else return b;
`else
    return b;
`endif
  endfunction

  // Expected data_out after edge e (counted from 1 after reset release).
  function automatic logic [7:0] expectAt(input int e);
    if (e < 9) return 8'h00;
    return expectByte(img[((e - 9) / 8) % 4]);
  endfunction

  task automatic loadImage(input logic [7:0] b0, b1, b2, b3);
    img[0] = b0; img[1] = b1; img[2] = b2; img[3] = b3;
    for (int i = 0; i < 4; i++) dut.source.mem[i] = img[i];
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int e, input logic [7:0] exp);
    assertions++;
    assert (data_out === exp) else begin
      failures++;
      $error("[TB] FAIL %s edge=%0d observed=%h expected=%h", tag, e, data_out, exp);
    end
  endtask

  task automatic resetDut();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("reset_hold", i, 8'h00);
    end
    reset = 1'b0;
  endtask

  task automatic runEdges(input string tag, input int n);
    for (int e = 1; e <= n; e++) begin
      applyStimulus();
      checkOutput(tag, e, expectAt(e));
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    reset      = 1'b1;

    $display("[TB] first byte latency and hold");
    loadImage(8'h48, 8'h65, 8'h6C, 8'h6C);
    resetDut();
    runEdges("latency", 36);

    $display("[TB] serial ordering");
    loadImage(8'h81, 8'h7E, 8'h00, 8'hFF);
    resetDut();
    runEdges("ordering", 41);

    $display("[TB] wrap-around");
    loadImage(8'h11, 8'h22, 8'h33, 8'h44);
    resetDut();
    runEdges("wrap", 57);

    $display("[TB] mid-frame reset");
    loadImage(8'hA5, 8'h3C, 8'h00, 8'hC3);
    resetDut();
    runEdges("pre_reset", 19);
    reset = 1'b1;
    applyStimulus();
    checkOutput("mid_reset", 20, 8'h00);
    reset = 1'b0;
    runEdges("post_reset", 35);

    $display("[TB] case folding");
    loadImage(8'h61, 8'h7A, 8'h41, 8'h5B);
    resetDut();
    runEdges("upper", 41);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
